uart_reg_bridge: RTL and testbench

- Next-generation serial control top: a PC reads and writes a bank of byte-wide control registers over UART.
- The bank replaces the fixed 8-LED command set.
- Instantiates the existing uart_rx and uart_tx, adds a framed binary command parser, a reply FIFO that decouples the parser from uart_tx, and an inter-byte timeout.
- Sits at chip top; register outputs drive LEDs or other board control.

---
 rtl/uart_bridge_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 44 ++++
 rtl/uart_rx.sv | 64 ++++++
 rtl/uart_tx.sv | 78 +++++++
 rtl/uart_reg_bridge.sv | 177 +++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state types for the UART register bridge.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    typedef enum logic [2:0] {
        P_IDLE,
        P_W_ADDR,
        P_W_DATA,
        P_R_ADDR,
        P_REPLY
    } parser_state_t;

    typedef enum logic {
        T_IDLE,
        T_WAIT
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers; head is shown combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; rx_dv pulses one cycle with rx_byte at mid stop bit. No reset.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;

    always_ff @(posedge clk) begin
        rx_meta <= rx_serial;
        rx_sync <= rx_meta;
        rx_dv   <= 1'b0;
        case (state)
            RX_IDLE: begin
                cnt     <= '0;
                bit_idx <= '0;
                if (!rx_sync) state <= RX_START;
            end
            RX_START: begin
                if (cnt >= HALF) begin
                    cnt   <= '0;
                    state <= rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt >= LAST) begin
                    cnt              <= '0;
                    rx_byte[bit_idx] <= rx_sync;
                    if (bit_idx == 3'd7) state <= RX_STOP;
                    else                 bit_idx <= bit_idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt >= LAST) begin
                    cnt   <= '0;
                    rx_dv <= rx_sync;
                    state <= RX_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            default: state <= RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; tx_done pulses as tx_active drops. No reset.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_active,
    output logic       tx_serial,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    data;
    logic          line_low;

    // Line stored inverted so an all-zero power-up state idles high.
    assign tx_serial = ~line_low;

    always_ff @(posedge clk) begin
        tx_done <= 1'b0;
        case (state)
            TX_IDLE: begin
                line_low <= 1'b0;
                cnt      <= '0;
                bit_idx  <= '0;
                if (tx_dv) begin
                    data      <= tx_byte;
                    tx_active <= 1'b1;
                    line_low  <= 1'b1;
                    state     <= TX_START;
                end
            end
            TX_START: begin
                if (cnt >= LAST) begin
                    cnt      <= '0;
                    line_low <= ~data[0];
                    state    <= TX_DATA;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt >= LAST) begin
                    cnt <= '0;
                    if (bit_idx == 3'd7) begin
                        line_low <= 1'b0;
                        state    <= TX_STOP;
                    end else begin
                        bit_idx  <= bit_idx + 1'b1;
                        data     <= {1'b0, data[7:1]};
                        line_low <= ~data[1];
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt >= LAST) begin
                    tx_done   <= 1'b1;
                    tx_active <= 1'b0;
                    state     <= TX_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            default: state <= TX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// UART-controlled byte register bank: framed W/R command parser, reply FIFO and TX drain.
module uart_reg_bridge #(
    parameter int CLKS_PER_BIT  = 5208,
    parameter int NUM_REGS      = 4,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CLKS  = 10 * CLKS_PER_BIT * 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx_pin,
    output logic                  uart_tx_pin,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  frame_err
);

    import uart_bridge_pkg::*;

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic          tx_done;

    parser_state_t state;
    tx_state_t     tstate;
    logic [7:0]    addr;
    logic [7:0]    reply;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    regs [NUM_REGS];

    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          tmo_hit;
    logic          rx_in_range;
    logic          addr_in_range;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rx_serial (uart_rx_pin),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (clk),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_serial (uart_tx_pin),
        .tx_done   (tx_done)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (reply),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign tmo_hit       = (tmo_cnt >= TMO_LAST);
    assign rx_in_range   = ({1'b0, rx_byte} < 9'(NUM_REGS));
    assign addr_in_range = ({1'b0, addr} < 9'(NUM_REGS));
    assign push          = (state == P_REPLY) && !full;
    assign pop           = (tstate == T_IDLE) && !empty && !tx_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= P_IDLE;
            frame_err <= 1'b0;
            tmo_cnt   <= '0;
            addr      <= '0;
            reply     <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            frame_err <= 1'b0;
            if (rx_dv || state == P_IDLE || state == P_REPLY) tmo_cnt <= '0;
            else                                              tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
                P_IDLE: begin
                    if (rx_dv) begin
                        if (rx_byte == OP_WR)      state <= P_W_ADDR;
                        else if (rx_byte == OP_RD) state <= P_R_ADDR;
                        else begin
                            reply     <= RSP_BAD;
                            frame_err <= 1'b1;
                            state     <= P_REPLY;
                        end
                    end
                end
                P_W_ADDR: begin
                    if (rx_dv) begin
                        addr  <= rx_byte;
                        state <= P_W_DATA;
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= P_IDLE;
                    end
                end
                P_W_DATA: begin
                    if (rx_dv) begin
                        state <= P_REPLY;
                        if (addr_in_range) begin
                            regs[addr[AW-1:0]] <= rx_byte;
                            reply              <= RSP_OK;
                        end else begin
                            reply     <= RSP_ERR;
                            frame_err <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= P_IDLE;
                    end
                end
                P_R_ADDR: begin
                    if (rx_dv) begin
                        state <= P_REPLY;
                        if (rx_in_range) begin
                            reply <= regs[rx_byte[AW-1:0]];
                        end else begin
                            reply     <= RSP_ERR;
                            frame_err <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= P_IDLE;
                    end
                end
                P_REPLY: begin
                    if (!full) state <= P_IDLE;
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    // TX_IDLE also waits on tx_active so a byte left in flight by rst finishes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            tstate  <= T_IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
        end else begin
            tx_dv <= 1'b0;
            case (tstate)
                T_IDLE: begin
                    if (pop) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= head;
                        tstate  <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (tx_done) tstate <= T_IDLE;
                end
                default: tstate <= T_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[8*i +: 8] = regs[i];
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench: serial command frames in, decoded reply bytes checked against a queue.
module tb_uart_reg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic [31:0] reg_out;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int err_wide = 0;
    int tx_overlap = 0;
    logic err_prev = 1'b0;
    bit mon_busy = 1'b0;
    logic [7:0] q[$];

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] rsp;
        int         errs;
        logic [31:0] regs;
    } vec_t;

    vec_t vecs[7];

    uart_reg_bridge #(
        .CLKS_PER_BIT  (8),
        .NUM_REGS      (4),
        .TX_FIFO_DEPTH (2),
        .TIMEOUT_CLKS  (400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_pin (rx_pin),
        .uart_tx_pin (tx_pin),
        .reg_out     (reg_out),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_clks);
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (8) @(negedge clk);
        end
        rx_pin = 1'b1;
        repeat (stop_clks - 1) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d replies pending, required 0", name, q.size());
            q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (frame_err) begin
            err_pulses++;
            if (err_prev) err_wide++;
        end
        err_prev = frame_err;
        if (dut.tx_dv && dut.tx_active) tx_overlap++;
    end

    // Line monitor: decodes each 8N1 byte at bit centres and checks it against the queue head.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_pin === 1'b0) begin
                mon_busy = 1'b1;
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = tx_pin;
                end
                repeat (8) @(negedge clk);
                chk("tx_stop_bit", {31'd0, tx_pin}, 32'd1);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected no byte", b);
                end else begin
                    chk("tx_reply", {24'd0, b}, {24'd0, q.pop_front()});
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int e0;
        bit seen;

        vecs[0] = '{3, 8'h57, 8'h01, 8'h3C, 8'h4B, 0, 32'h00A53C00};
        vecs[1] = '{2, 8'h52, 8'h01, 8'h00, 8'h3C, 0, 32'h00A53C00};
        vecs[2] = '{3, 8'h57, 8'h07, 8'hFF, 8'h45, 1, 32'h00A53C00};
        vecs[3] = '{2, 8'h52, 8'h04, 8'h00, 8'h45, 1, 32'h00A53C00};
        vecs[4] = '{1, 8'h99, 8'h00, 8'h00, 8'h3F, 1, 32'h00A53C00};
        vecs[5] = '{2, 8'h52, 8'h02, 8'h00, 8'hA5, 0, 32'h00A53C00};
        vecs[6] = '{3, 8'h57, 8'h03, 8'h7E, 8'h4B, 0, 32'h7EA53C00};

        repeat (5) @(negedge clk);
        chk("reset_reg_out", reg_out, 32'h0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_tx_pin", {31'd0, tx_pin}, 32'd1);

        // First write: register must update on the edge that samples the last rx_dv.
        e0 = err_pulses;
        q.push_back(8'h4B);
        send_byte(8'h57, 8);
        send_byte(8'h02, 8);
        seen = 1'b0;
        fork
            send_byte(8'hA5, 8);
            begin
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    if (dut.rx_dv) begin
                        seen = 1'b1;
                        chk("wr_before_edge", {24'd0, reg_out[23:16]}, 32'h0);
                        @(posedge clk);
                        #1;
                        chk("wr_after_edge", reg_out, 32'h00A50000);
                    end
                end
                if (!seen) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_rx_dv_wait: no rx_dv within 200 clks, required one");
                end
            end
        join
        drain("first_write");
        chk("first_write_err", e0 - err_pulses, 32'd0);

        for (int v = 0; v < 7; v++) begin
            e0 = err_pulses;
            q.push_back(vecs[v].rsp);
            send_byte(vecs[v].b0, 8);
            if (vecs[v].n >= 2) send_byte(vecs[v].b1, 8);
            if (vecs[v].n >= 3) send_byte(vecs[v].b2, 8);
            drain("vec");
            chk($sformatf("vec%0d_frame_err", v), err_pulses - e0, vecs[v].errs);
            chk($sformatf("vec%0d_reg_out", v), reg_out, vecs[v].regs);
        end

        // Inter-byte timeout, then a stray byte seen as a bad opcode.
        e0 = err_pulses;
        send_byte(8'h57, 8);
        send_byte(8'h00, 8);
        repeat (500) @(negedge clk);
        chk("timeout_err", err_pulses - e0, 32'd1);
        chk("timeout_no_reply", q.size(), 32'd0);
        q.push_back(8'h3F);
        send_byte(8'h11, 8);
        drain("stray");
        chk("stray_err", err_pulses - e0, 32'd2);
        chk("timeout_reg_out", reg_out, 32'h7EA53C00);

        // Back-to-back reads with short stop bits queue replies behind the busy transmitter.
        e0 = err_pulses;
        q.push_back(8'h00);
        q.push_back(8'h3C);
        q.push_back(8'hA5);
        send_byte(8'h52, 5);
        send_byte(8'h00, 5);
        send_byte(8'h52, 5);
        send_byte(8'h01, 5);
        send_byte(8'h52, 5);
        send_byte(8'h02, 5);
        drain("burst");
        chk("burst_err", err_pulses - e0, 32'd0);

        // Reset in the middle of a write frame.
        send_byte(8'h57, 8);
        send_byte(8'h03, 8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midframe_rst_reg_out", reg_out, 32'h0);
        q.push_back(8'h00);
        send_byte(8'h52, 8);
        send_byte(8'h03, 8);
        drain("post_rst_read");
        chk("post_rst_reg_out", reg_out, 32'h0);

        chk("frame_err_width", err_wide, 32'd0);
        chk("tx_dv_while_active", tx_overlap, 32'd0);
        chk("queue_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
